pool_a1_cu: RTL and testbench
=============================

Name: pool_a1_cu

Overview:
- Control unit for the 2x2/stride-2 pooling layer that follows the first convolution layer; the consumer end of the conv layer's ping-pong feature-map handshake.
- Accepts one finished IFM_SIZE x IFM_SIZE map per start_from_previous and reads it in 2x2 window order.
- Drives the pooling datapath's first/enable/last strobes and writes one pooled value per window into the next layer's ping-pong memory.
- Uses the same start_to_next / end_from_next handshake toward the next layer.

Parameters:
- IFM_SIZE, 30, input map side; must be even.
- POOL_WRITE_DELAY, 2, cycles from pool_last to result-valid in the pooling datapath.
- IFM_SIZE_NEXT, IFM_SIZE/2, output map side.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), read address width.
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), write address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_from_previous  in  1  previous layer has a full map ready
- end_to_previous  out  1  block can accept a map (ready)
- ifm_sel_current  out  1  ping-pong bank being read
- ifm_enable_read_current  out  1  read strobe
- ifm_address_read_current  out  ADDRESS_SIZE_IFM  read address
- pool_first  out  1  data on bus is window element 0
- pool_enable  out  1  data on bus is valid
- pool_last  out  1  data on bus is window element 3
- ifm_enable_write_next  out  1  write pooled result
- ifm_address_write_next  out  ADDRESS_SIZE_NEXT_IFM  write address
- start_to_next  out  1  one-cycle pulse: next memory holds a full map
- end_from_next  in  1  next layer ready to take a map
- ifm_sel_next  out  1  ping-pong bank being written

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0 except end_to_previous=1; read FSM IDLE; output FSM EMPTY; all counters 0.
- Read FSM states: IDLE, READ, DRAIN.
  - IDLE: end_to_previous = ~out_full. If start_from_previous & ~out_full, go to READ next cycle. Otherwise start is ignored and not queued; start is also ignored in READ and DRAIN.
  - READ: ifm_enable_read_current=1 every cycle for exactly IFM_SIZE*IFM_SIZE cycles, no gaps.
  - Counters in READ: elem (0..3) is the fastest; then out_col (0..IFM_SIZE_NEXT-1); then out_row.
  - Read address = (2*out_row + elem[1])*IFM_SIZE + 2*out_col + elem[0].
  - On the final read (out_row=out_col=IFM_SIZE_NEXT-1, elem=3): go to DRAIN, toggle ifm_sel_current, clear counters.
  - DRAIN: lasts POOL_WRITE_DELAY+2 cycles, until the last write has issued. Then set out_full and return to IDLE.
- Strobe timing (memory read latency is 1):
  - pool_enable = read enable delayed 1.
  - pool_first = (elem==0 & read) delayed 1.
  - pool_last = (elem==3 & read) delayed 1.
  - ifm_enable_write_next = pool_last delayed POOL_WRITE_DELAY.
- Write address: starts at 0 and increments after each write. It wraps to 0 after IFM_SIZE_NEXT^2-1 is written; that write sets out_full.
- Output FSM states: EMPTY, FULL.
  - FULL: start_to_next = end_from_next (one-cycle pulse). On that cycle, toggle ifm_sel_next and go to EMPTY.
  - If end_from_next is already high on entry to FULL, the pulse happens on the first FULL cycle.
- Simultaneous events: start_from_previous in the same cycle that FULL clears is accepted (end_to_previous uses next-state out_full).
- Reset mid-map: everything returns to reset values next cycle, including the ping-pong selects. In-flight strobes are dropped.

Test Plan:
- Single map, IFM_SIZE=30, end_from_next=1:
  - First 8 read addresses are 0,1,30,31,2,3,32,33.
  - Exactly 900 reads; then 225 writes on addresses 0..224.
  - One start_to_next pulse; ifm_sel_current and ifm_sel_next both become 1.
- Row wrap: reads 57-60 are 28,29,58,59; reads 61-64 are 60,61,90,91. Final read is 899.
- Strobe alignment:
  - pool_first on cycles 1,5,9,... and pool_last on cycles 4,8,... after the first read.
  - First write 2 cycles after the first pool_last, at address 0.
- Back-pressure:
  - Hold end_from_next=0 after map 1: out_full stays 1, end_to_previous=0, and a start_from_previous pulse is ignored (no reads).
  - Raise end_from_next: start_to_next pulses once, then end_to_previous=1.
- Reset after 400 reads:
  - Next cycle: read enable 0, address 0, end_to_previous=1, sels 0.
  - A new start reads from address 0 again.
- Back-to-back maps with start asserted in the same cycle that FULL clears:
  - Second map begins reading without an idle gap.
  - ifm_sel_current returns to 0 after the second map.

Source files
------------

// File: rtl/pool_a1_cu.sv
// Control unit for the 2x2/stride-2 pooling stage behind conv layer 1.
// Reads one IFM_SIZE x IFM_SIZE map in 2x2 window order and drives the pooling
// datapath strobes. Writes one pooled value per window into the next layer's
// ping-pong memory.
//
// Read FSM
//   state    | meaning
//   RD_IDLE  | waiting for a map; ready only while the output bank is free
//   RD_READ  | one read per cycle, window element fastest
//   RD_DRAIN | reads done, waiting for the last pooled write to issue
//
// Output FSM
//   state     | meaning
//   OUT_EMPTY | next-layer bank is being filled or is free
//   OUT_FULL  | next-layer bank holds a full map, waiting for end_from_next
module pool_a1_cu #(
    parameter int IFM_SIZE              = 30,
    parameter int POOL_WRITE_DELAY      = 2,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    output logic                             end_to_previous,
    output logic                             ifm_sel_current,
    output logic                             ifm_enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
    output logic                             pool_first,
    output logic                             pool_enable,
    output logic                             pool_last,
    output logic                             ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
    output logic                             start_to_next,
    input  logic                             end_from_next,
    output logic                             ifm_sel_next
);

    typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    localparam int CNT_W = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
    localparam int DRN_W = $clog2(POOL_WRITE_DELAY + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IFM_SIZE_NEXT - 1);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] WR_LAST =
        ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    // Drain covers the read-to-strobe cycle, the datapath delay and one more
    // cycle so the last write has issued before the read FSM goes idle.
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(POOL_WRITE_DELAY + 1);

    rd_state_t  rd_state_q, rd_state_d;
    out_state_t out_state_q, out_state_d;

    logic [1:0]                       elem_q, elem_d;
    logic [CNT_W-1:0]                 col_q, col_d;
    logic [CNT_W-1:0]                 row_q, row_d;
    logic [DRN_W-1:0]                 drain_q, drain_d;
    logic                             sel_cur_q, sel_cur_d;
    logic                             sel_next_q, sel_next_d;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_q, wr_addr_d;
    logic                             en_q, first_q, last_q;
    logic [POOL_WRITE_DELAY-1:0]      wr_pipe_q;

    logic                        rd_en;
    logic                        wr_en;
    logic                        last_wr;
    logic                        out_full_d;
    logic [ADDRESS_SIZE_IFM-1:0] row_term;
    logic [ADDRESS_SIZE_IFM-1:0] col_term;

    assign rd_en   = (rd_state_q == RD_READ);
    assign wr_en   = wr_pipe_q[POOL_WRITE_DELAY-1];
    assign last_wr = wr_en && (wr_addr_q == WR_LAST);

    // Window-order read address: row = 2*out_row + elem[1], col = 2*out_col + elem[0]
    always_comb begin
        row_term = ADDRESS_SIZE_IFM'({row_q, elem_q[1]});
        col_term = ADDRESS_SIZE_IFM'({col_q, elem_q[0]});
        ifm_address_read_current = row_term * ADDRESS_SIZE_IFM'(IFM_SIZE) + col_term;
    end

    // Output FSM and write address; out_full_d lets a freed bank be reused the same cycle
    always_comb begin
        out_state_d   = out_state_q;
        sel_next_d    = sel_next_q;
        start_to_next = 1'b0;
        wr_addr_d     = wr_addr_q;
        if (wr_en) begin
            wr_addr_d = last_wr ? '0 : wr_addr_q + 1'b1;
        end
        case (out_state_q)
            OUT_EMPTY: begin
                if (last_wr) begin
                    out_state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (end_from_next) begin
                    start_to_next = 1'b1;
                    sel_next_d    = ~sel_next_q;
                    out_state_d   = OUT_EMPTY;
                end
            end
            default: out_state_d = OUT_EMPTY;
        endcase
        out_full_d = (out_state_d == OUT_FULL);
    end

    // Read FSM and window counters
    always_comb begin
        rd_state_d      = rd_state_q;
        elem_d          = elem_q;
        col_d           = col_q;
        row_d           = row_q;
        drain_d         = drain_q;
        sel_cur_d       = sel_cur_q;
        end_to_previous = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                end_to_previous = ~out_full_d;
                if (start_from_previous && !out_full_d) begin
                    rd_state_d = RD_READ;
                end
            end
            RD_READ: begin
                elem_d = elem_q + 2'd1;
                if (elem_q == 2'd3) begin
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            row_d      = '0;
                            sel_cur_d  = ~sel_cur_q;
                            drain_d    = DRAIN_LOAD;
                            rd_state_d = RD_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            RD_DRAIN: begin
                if (drain_q == '0) begin
                    rd_state_d = RD_IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // State, counters and strobe pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q  <= RD_IDLE;
            out_state_q <= OUT_EMPTY;
            elem_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            drain_q     <= '0;
            sel_cur_q   <= 1'b0;
            sel_next_q  <= 1'b0;
            wr_addr_q   <= '0;
            en_q        <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            wr_pipe_q   <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            out_state_q <= out_state_d;
            elem_q      <= elem_d;
            col_q       <= col_d;
            row_q       <= row_d;
            drain_q     <= drain_d;
            sel_cur_q   <= sel_cur_d;
            sel_next_q  <= sel_next_d;
            wr_addr_q   <= wr_addr_d;
            en_q        <= rd_en;
            first_q     <= rd_en && (elem_q == 2'd0);
            last_q      <= rd_en && (elem_q == 2'd3);
            wr_pipe_q   <= (wr_pipe_q << 1) | POOL_WRITE_DELAY'(last_q);
        end
    end

    assign ifm_sel_current        = sel_cur_q;
    assign ifm_enable_read_current = rd_en;
    assign pool_enable            = en_q;
    assign pool_first             = first_q;
    assign pool_last              = last_q;
    assign ifm_enable_write_next  = wr_en;
    assign ifm_address_write_next = wr_addr_q;
    assign ifm_sel_next           = sel_next_q;

endmodule

// File: tb/tb_pool_a1_cu.sv
// Scoreboard bench for pool_a1_cu: expected reads, strobes and writes are
// queued when a map is started and consumed as the DUT produces them.
module tb_pool_a1_cu;

    localparam int N   = 30;
    localparam int NN  = N / 2;
    localparam int AW  = $clog2(N * N);
    localparam int AWN = $clog2(NN * NN);

    logic           clk = 1'b0;
    logic           reset;
    logic           start_from_previous;
    logic           end_to_previous;
    logic           ifm_sel_current;
    logic           ifm_enable_read_current;
    logic [AW-1:0]  ifm_address_read_current;
    logic           pool_first;
    logic           pool_enable;
    logic           pool_last;
    logic           ifm_enable_write_next;
    logic [AWN-1:0] ifm_address_write_next;
    logic           start_to_next;
    logic           end_from_next;
    logic           ifm_sel_next;

    pool_a1_cu #(.IFM_SIZE(N), .POOL_WRITE_DELAY(2)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start_from_previous      (start_from_previous),
        .end_to_previous          (end_to_previous),
        .ifm_sel_current          (ifm_sel_current),
        .ifm_enable_read_current  (ifm_enable_read_current),
        .ifm_address_read_current (ifm_address_read_current),
        .pool_first               (pool_first),
        .pool_enable              (pool_enable),
        .pool_last                (pool_last),
        .ifm_enable_write_next    (ifm_enable_write_next),
        .ifm_address_write_next   (ifm_address_write_next),
        .start_to_next            (start_to_next),
        .end_from_next            (end_from_next),
        .ifm_sel_next             (ifm_sel_next)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int rd_q[$];
    int strb_q[$];
    int wr_q[$];

    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   pulse_cnt = 0;
    int   rd_run = 0;
    logic rd_d1 = 1'b0;
    logic last_d1 = 1'b0;
    logic last_d2 = 1'b0;
    logic prev_stn = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected read addresses, {first,last} strobes and write addresses of one map
    task automatic push_map();
        for (int r = 0; r < NN; r++)
            for (int c = 0; c < NN; c++)
                for (int e = 0; e < 4; e++) begin
                    rd_q.push_back((2 * r + e / 2) * N + 2 * c + e % 2);
                    strb_q.push_back((e == 0) ? 2 : ((e == 3) ? 1 : 0));
                end
        for (int w = 0; w < NN * NN; w++) wr_q.push_back(w);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_from_previous = 1'b1;
        @(posedge clk); #1 start_from_previous = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < 3000 && wr_cnt < target; i++) @(negedge clk);
        check("wr_timeout", int'(wr_cnt >= target), 1);
    endtask

    // Monitor: consumes scoreboard entries as outputs appear
    always @(negedge clk) begin
        if (reset) begin
            rd_d1 = 1'b0; last_d1 = 1'b0; last_d2 = 1'b0; prev_stn = 1'b0; rd_run = 0;
        end else begin
            if (ifm_enable_read_current) begin
                rd_cnt++;
                rd_run++;
                if (rd_q.size() == 0) check("rd_unexpected", int'(ifm_address_read_current), -1);
                else check("rd_addr", int'(ifm_address_read_current), rd_q.pop_front());
            end else if (rd_run != 0) begin
                check("rd_burst_len", rd_run, N * N);
                rd_run = 0;
            end
            if (pool_enable || rd_d1) check("en_align", int'(pool_enable), int'(rd_d1));
            if (pool_enable) begin
                if (strb_q.size() == 0) check("strobe_unexpected", int'({pool_first, pool_last}), -1);
                else check("strobe_fl", int'({pool_first, pool_last}), strb_q.pop_front());
            end else if (pool_first || pool_last) begin
                check("strobe_no_en", int'({pool_first, pool_last}), 0);
            end
            if (ifm_enable_write_next || last_d2)
                check("wr_align", int'(ifm_enable_write_next), int'(last_d2));
            if (ifm_enable_write_next) begin
                wr_cnt++;
                if (wr_q.size() == 0) check("wr_unexpected", int'(ifm_address_write_next), -1);
                else check("wr_addr", int'(ifm_address_write_next), wr_q.pop_front());
            end
            if (start_to_next) begin
                pulse_cnt++;
                check("stn_width", int'(prev_stn), 0);
            end
            prev_stn = start_to_next;
            last_d2  = last_d1;
            last_d1  = pool_last;
            rd_d1    = ifm_enable_read_current;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wr_base;
        reset = 1'b1;
        start_from_previous = 1'b0;
        end_from_next = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_end_to_prev", int'(end_to_previous), 1);
        check("rst_rd_en", int'(ifm_enable_read_current), 0);
        check("rst_rd_addr", int'(ifm_address_read_current), 0);
        check("rst_pool_strobes", int'({pool_first, pool_enable, pool_last}), 0);
        check("rst_wr_en", int'(ifm_enable_write_next), 0);
        check("rst_wr_addr", int'(ifm_address_write_next), 0);
        check("rst_stn", int'(start_to_next), 0);
        check("rst_sels", int'({ifm_sel_current, ifm_sel_next}), 0);

        // Map 1, next layer ready
        push_map();
        pulse_start();
        wait_wr(NN * NN);
        repeat (3) @(negedge clk);
        check("m1_reads", rd_cnt, N * N);
        check("m1_writes", wr_cnt, NN * NN);
        check("m1_pulses", pulse_cnt, 1);
        check("m1_sel_cur", int'(ifm_sel_current), 1);
        check("m1_sel_next", int'(ifm_sel_next), 1);
        check("m1_queues", rd_q.size() + strb_q.size() + wr_q.size(), 0);
        check("m1_ready", int'(end_to_previous), 1);

        // Map 2 with back-pressure
        end_from_next = 1'b0;
        push_map();
        pulse_start();
        wait_wr(2 * NN * NN);
        repeat (5) @(negedge clk);
        check("bp_not_ready", int'(end_to_previous), 0);
        check("bp_no_pulse", pulse_cnt, 1);
        check("bp_sel_cur", int'(ifm_sel_current), 0);
        pulse_start();
        repeat (20) @(negedge clk);
        check("bp_start_ignored", rd_cnt, 2 * N * N);
        @(posedge clk); #1 end_from_next = 1'b1;
        @(negedge clk);
        check("bp_stn_pulse", int'(start_to_next), 1);
        @(negedge clk);
        check("bp_stn_low", int'(start_to_next), 0);
        check("bp_pulses", pulse_cnt, 2);
        check("bp_ready", int'(end_to_previous), 1);
        check("bp_sel_next", int'(ifm_sel_next), 0);

        // Map 3 held full, map 4 started in the same cycle FULL clears
        end_from_next = 1'b0;
        push_map();
        pulse_start();
        wait_wr(3 * NN * NN);
        repeat (5) @(negedge clk);
        check("b2b_full", int'(end_to_previous), 0);
        push_map();
        @(posedge clk); #1 start_from_previous = 1'b1; end_from_next = 1'b1;
        @(negedge clk);
        check("b2b_stn", int'(start_to_next), 1);
        check("b2b_ready", int'(end_to_previous), 1);
        @(posedge clk); #1 start_from_previous = 1'b0;
        @(negedge clk);
        check("b2b_no_gap", int'(ifm_enable_read_current), 1);
        check("b2b_addr0", int'(ifm_address_read_current), 0);
        wait_wr(4 * NN * NN);
        repeat (3) @(negedge clk);
        check("b2b_sel_cur", int'(ifm_sel_current), 0);
        check("b2b_sel_next", int'(ifm_sel_next), 0);
        check("b2b_pulses", pulse_cnt, 4);
        check("b2b_reads", rd_cnt, 4 * N * N);

        // Reset in the middle of map 5
        push_map();
        base = rd_cnt;
        pulse_start();
        for (int i = 0; i < 1000 && rd_cnt < base + 400; i++) @(negedge clk);
        check("mid_reads_seen", int'(rd_cnt >= base + 400), 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        rd_q.delete();
        strb_q.delete();
        wr_q.delete();
        @(negedge clk);
        check("mid_rd_en", int'(ifm_enable_read_current), 0);
        check("mid_rd_addr", int'(ifm_address_read_current), 0);
        check("mid_ready", int'(end_to_previous), 1);
        check("mid_sels", int'({ifm_sel_current, ifm_sel_next}), 0);
        check("mid_strobes", int'({pool_first, pool_enable, pool_last, ifm_enable_write_next}), 0);
        check("mid_wr_addr", int'(ifm_address_write_next), 0);

        // Map 6 after reset starts from address 0 again
        wr_base = wr_cnt;
        push_map();
        pulse_start();
        wait_wr(wr_base + NN * NN);
        repeat (3) @(negedge clk);
        check("m6_sel_cur", int'(ifm_sel_current), 1);
        check("m6_sel_next", int'(ifm_sel_next), 1);
        check("m6_queues", rd_q.size() + strb_q.size() + wr_q.size(), 0);
        check("m6_ready", int'(end_to_previous), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
